// File: rtl/moesi_pkg.sv
// moesi_pkg: shared definitions for the snoop-side tag controller.
//   - MOESI state encodings (M=000, O=001, E=010, S=011, I=100)
//   - snoop bus transaction type
//   - snoop_next(): next MOESI state plus supply/dirty response for a snoop
package moesi_pkg;

  localparam logic [2:0] ST_M = 3'b000;
  localparam logic [2:0] ST_O = 3'b001;
  localparam logic [2:0] ST_E = 3'b010;
  localparam logic [2:0] ST_S = 3'b011;
  localparam logic [2:0] ST_I = 3'b100;

  typedef enum logic [1:0] {
    SNP_RD   = 2'b00,
    SNP_RDX  = 2'b01,
    SNP_UPGR = 2'b10,
    SNP_RSVD = 2'b11
  } snoop_type_t;

  typedef struct packed {
    logic [2:0] next;
    logic       supply;
    logic       dirty;
  } snoop_outcome_t;

  // Outcome of a snoop against a line currently in state cur. States and
  // types with no transition keep the line unchanged and supply nothing.
  function automatic snoop_outcome_t snoop_next(input logic [2:0] cur,
                                                input snoop_type_t typ);
    snoop_outcome_t o;
    o = '{next: cur, supply: 1'b0, dirty: 1'b0};
    case (typ)
      SNP_RD: begin
        case (cur)
          ST_M, ST_O: o = '{next: ST_O, supply: 1'b1, dirty: 1'b1};
          ST_E:       o = '{next: ST_S, supply: 1'b1, dirty: 1'b0};
          default:    ;
        endcase
      end
      SNP_RDX: begin
        case (cur)
          ST_M, ST_O: o = '{next: ST_I, supply: 1'b1, dirty: 1'b1};
          ST_E:       o = '{next: ST_I, supply: 1'b1, dirty: 1'b0};
          ST_S:       o = '{next: ST_I, supply: 1'b0, dirty: 1'b0};
          default:    ;
        endcase
      end
      SNP_UPGR: begin
        if (cur != ST_I) o = '{next: ST_I, supply: 1'b0, dirty: 1'b0};
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/snoop_hit_detect.sv
// snoop_hit_detect: combinational tag compare across all ways of one set,
// with lowest-index priority when several ways match.
// Ports:
//   tag     - tag being snooped
//   tags    - per-way stored tags
//   valids  - per-way valid bits
//   states  - per-way MOESI states
//   hit     - some way holds the line in a non-I state
//   way     - lowest matching way (0 on miss)
//   state   - MOESI state of that way (I on miss)
module snoop_hit_detect
  import moesi_pkg::*;
#(
  parameter int WAYS      = 4,
  parameter int TAG_WIDTH = 19,
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [TAG_WIDTH-1:0]            tag,
  input  logic [WAYS-1:0][TAG_WIDTH-1:0]  tags,
  input  logic [WAYS-1:0]                 valids,
  input  logic [WAYS-1:0][2:0]            states,
  output logic                            hit,
  output logic [WAY_W-1:0]                way,
  output logic [2:0]                      state
);

  // Scan from the top way down so the lowest matching way is left last.
  always_comb begin
    hit   = 1'b0;
    way   = '0;
    state = ST_I;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valids[i] && (states[i] != ST_I) && (tags[i] == tag)) begin
        hit   = 1'b1;
        way   = WAY_W'(i);
        state = states[i];
      end
    end
  end

endmodule

// File: rtl/snoop_tag_controller.sv
// snoop_tag_controller: serves one bus snoop at a time against the MOESI tag
// array. It looks up the set, computes the next state, arbitrates for the
// shared tag write port, commits the change and returns a hit/supply/dirty
// response.
// Ports:
//   clk, rst_n                    - clock, async active-low reset
//   snp_req_*                     - snoop request (valid/ready, addr, type)
//   tag_rd_set, tag_rd_*          - tag array snoop read port
//   tag_wr_req / tag_wr_gnt       - write-port arbitration
//   tag_wr_*                      - tag array write port (en pulses one cycle)
//   snp_resp_*                    - snoop response (valid/ready + fields)
//   snp_stat_hits, snp_stat_invals - statistics counters
// Build option: define SNOOP_STATS_EN to implement the saturating counters;
// otherwise both counters are tied to 0.
module snoop_tag_controller
  import moesi_pkg::*;
#(
  parameter int SETS       = 128,
  parameter int WAYS       = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = ADDR_WIDTH - $clog2(SETS) - 6,
  parameter int LRU_BITS   = 2,
  localparam int SET_W     = $clog2(SETS),
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             snp_req_valid,
  output logic                             snp_req_ready,
  input  logic [ADDR_WIDTH-1:0]            snp_req_addr,
  input  logic [1:0]                       snp_req_type,
  output logic [SET_W-1:0]                 tag_rd_set,
  input  logic [WAYS-1:0][TAG_WIDTH-1:0]   tag_rd_tags,
  input  logic [WAYS-1:0]                  tag_rd_valids,
  input  logic [WAYS-1:0][2:0]             tag_rd_states,
  input  logic [WAYS-1:0][LRU_BITS-1:0]    tag_rd_lru,
  output logic                             tag_wr_req,
  input  logic                             tag_wr_gnt,
  output logic                             tag_wr_en,
  output logic [SET_W-1:0]                 tag_wr_set,
  output logic [WAY_W-1:0]                 tag_wr_way,
  output logic [TAG_WIDTH-1:0]             tag_wr_tag,
  output logic                             tag_wr_valid,
  output logic [2:0]                       tag_wr_state,
  output logic [LRU_BITS-1:0]              tag_wr_lru,
  output logic                             snp_resp_valid,
  input  logic                             snp_resp_ready,
  output logic                             snp_resp_hit,
  output logic                             snp_resp_supply,
  output logic                             snp_resp_dirty,
  output logic [WAY_W-1:0]                 snp_resp_way,
  output logic [2:0]                       snp_resp_prev_state,
  output logic [31:0]                      snp_stat_hits,
  output logic [31:0]                      snp_stat_invals
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]           fsm_q;
  logic [SET_W-1:0]     set_p0;
  logic [TAG_WIDTH-1:0] tag_p0;
  snoop_type_t          type_p0;
  logic                 hit_p1, supply_p1, dirty_p1;
  logic [WAY_W-1:0]     way_p1;
  logic [2:0]           prev_p1;

  logic                 det_hit;
  logic [WAY_W-1:0]     det_way;
  logic [2:0]           det_state;
  snoop_outcome_t       eval;
  logic                 eval_hit, eval_need, eval_load;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^snp_req_addr[5:0];

  snoop_hit_detect #(.WAYS(WAYS), .TAG_WIDTH(TAG_WIDTH)) u_hit (
    .tag    (tag_p0),
    .tags   (tag_rd_tags),
    .valids (tag_rd_valids),
    .states (tag_rd_states),
    .hit    (det_hit),
    .way    (det_way),
    .state  (det_state)
  );

  // Evaluation shared by LOOKUP and the grant cycle; reserved types never hit.
  always_comb begin
    eval      = snoop_next(det_state, type_p0);
    eval_hit  = det_hit && (type_p0 != SNP_RSVD);
    eval_need = eval_hit && (eval.next != det_state);
    eval_load = (fsm_q == LOOKUP) || ((fsm_q == WRITE) && tag_wr_gnt);
  end

  // ---- stage p0: request capture and FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      set_p0  <= '0;
      tag_p0  <= '0;
      type_p0 <= SNP_RD;
    end else begin
      case (fsm_q)
        IDLE: if (snp_req_valid) begin
          set_p0  <= snp_req_addr[6 +: SET_W];
          tag_p0  <= snp_req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
          type_p0 <= snoop_type_t'(snp_req_type);
          fsm_q   <= LOOKUP;
        end
        LOOKUP: fsm_q <= eval_need ? WRITE : RESP;
        WRITE:  if (tag_wr_gnt) fsm_q <= RESP;
        default: if (snp_resp_ready) fsm_q <= IDLE;
      endcase
    end
  end

  // ---- stage p1: lookup / grant-cycle result held for the response ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_p1    <= 1'b0;
      supply_p1 <= 1'b0;
      dirty_p1  <= 1'b0;
      way_p1    <= '0;
      prev_p1   <= ST_I;
    end else if (eval_load) begin
      hit_p1    <= eval_hit;
      supply_p1 <= eval_hit && eval.supply;
      dirty_p1  <= eval_hit && eval.dirty;
      way_p1    <= eval_hit ? det_way : '0;
      prev_p1   <= eval_hit ? det_state : ST_I;
    end
  end

  assign snp_req_ready = (fsm_q == IDLE);
  assign tag_rd_set    = ((fsm_q == LOOKUP) || (fsm_q == WRITE)) ? set_p0 : '0;
  assign tag_wr_req    = (fsm_q == WRITE);

  // The write commits whatever the grant-cycle read says, so a line the core
  // dropped while we waited is simply not written.
  assign tag_wr_en    = (fsm_q == WRITE) && tag_wr_gnt && eval_need;
  assign tag_wr_set   = tag_wr_en ? set_p0 : '0;
  assign tag_wr_way   = tag_wr_en ? det_way : '0;
  assign tag_wr_tag   = tag_wr_en ? tag_rd_tags[det_way] : '0;
  assign tag_wr_lru   = tag_wr_en ? tag_rd_lru[det_way] : '0;
  assign tag_wr_state = tag_wr_en ? eval.next : '0;
  assign tag_wr_valid = tag_wr_en && (eval.next != ST_I);

  assign snp_resp_valid      = (fsm_q == RESP);
  assign snp_resp_hit        = snp_resp_valid && hit_p1;
  assign snp_resp_supply     = snp_resp_valid && supply_p1;
  assign snp_resp_dirty      = snp_resp_valid && dirty_p1;
  assign snp_resp_way        = snp_resp_valid ? way_p1 : '0;
  assign snp_resp_prev_state = snp_resp_valid ? prev_p1 : '0;

`ifdef SNOOP_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] hits_q, invals_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      invals_q <= '0;
    end else begin
      if (snp_resp_ready && snp_resp_hit) hits_q <= sat_inc(hits_q);
      if (tag_wr_en && (tag_wr_state == ST_I)) invals_q <= sat_inc(invals_q);
    end
  end

  assign snp_stat_hits   = hits_q;
  assign snp_stat_invals = invals_q;
`else
  assign snp_stat_hits   = '0;
  assign snp_stat_invals = '0;
`endif

endmodule

// File: tb/tb_snoop_tag_controller.sv
// tb_snoop_tag_controller: directed bench with a behavioural tag array,
// a responsive write-port arbiter and an expected-response scoreboard.
module tb_snoop_tag_controller;
  localparam int SETS = 128, WAYS = 4, AW = 32, TW = 19, LB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic snp_req_valid = 1'b0, snp_req_ready;
  logic [AW-1:0] snp_req_addr = '0;
  logic [1:0] snp_req_type = '0;
  logic [6:0] tag_rd_set;
  logic [WAYS-1:0][TW-1:0] tag_rd_tags;
  logic [WAYS-1:0] tag_rd_valids;
  logic [WAYS-1:0][2:0] tag_rd_states;
  logic [WAYS-1:0][LB-1:0] tag_rd_lru;
  logic tag_wr_req, tag_wr_gnt = 1'b0, tag_wr_en;
  logic [6:0] tag_wr_set;
  logic [1:0] tag_wr_way;
  logic [TW-1:0] tag_wr_tag;
  logic tag_wr_valid;
  logic [2:0] tag_wr_state;
  logic [LB-1:0] tag_wr_lru;
  logic snp_resp_valid, snp_resp_ready = 1'b0;
  logic snp_resp_hit, snp_resp_supply, snp_resp_dirty;
  logic [1:0] snp_resp_way;
  logic [2:0] snp_resp_prev_state;
  logic [31:0] snp_stat_hits, snp_stat_invals;

  always #5 clk = ~clk;

  snoop_tag_controller dut (
    .clk(clk), .rst_n(rst_n),
    .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready),
    .snp_req_addr(snp_req_addr), .snp_req_type(snp_req_type),
    .tag_rd_set(tag_rd_set), .tag_rd_tags(tag_rd_tags), .tag_rd_valids(tag_rd_valids),
    .tag_rd_states(tag_rd_states), .tag_rd_lru(tag_rd_lru),
    .tag_wr_req(tag_wr_req), .tag_wr_gnt(tag_wr_gnt), .tag_wr_en(tag_wr_en),
    .tag_wr_set(tag_wr_set), .tag_wr_way(tag_wr_way), .tag_wr_tag(tag_wr_tag),
    .tag_wr_valid(tag_wr_valid), .tag_wr_state(tag_wr_state), .tag_wr_lru(tag_wr_lru),
    .snp_resp_valid(snp_resp_valid), .snp_resp_ready(snp_resp_ready),
    .snp_resp_hit(snp_resp_hit), .snp_resp_supply(snp_resp_supply),
    .snp_resp_dirty(snp_resp_dirty), .snp_resp_way(snp_resp_way),
    .snp_resp_prev_state(snp_resp_prev_state),
    .snp_stat_hits(snp_stat_hits), .snp_stat_invals(snp_stat_invals)
  );

  // Behavioural tag array; read port is combinational on tag_rd_set.
  logic [TW-1:0] m_tag [SETS][WAYS];
  logic          m_val [SETS][WAYS];
  logic [2:0]    m_st  [SETS][WAYS];
  logic [LB-1:0] m_lru [SETS][WAYS];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      tag_rd_tags[w]   = m_tag[tag_rd_set][w];
      tag_rd_valids[w] = m_val[tag_rd_set][w];
      tag_rd_states[w] = m_st[tag_rd_set][w];
      tag_rd_lru[w]    = m_lru[tag_rd_set][w];
    end
  end

  typedef struct {
    logic hit, supply, dirty;
    logic [1:0] way;
    logic [2:0] prev;
    int lat, reqc, wrc;
    logic [2:0] wst;
    logic wval;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic h, s, d, input logic [1:0] w, input logic [2:0] p,
                              input int lat, reqc, wrc, input logic [2:0] wst, input logic wval);
    exp_t e;
    e.hit = h; e.supply = s; e.dirty = d; e.way = w; e.prev = p;
    e.lat = lat; e.reqc = reqc; e.wrc = wrc; e.wst = wst; e.wval = wval;
    return e;
  endfunction

  function automatic logic [AW-1:0] mk_addr(input logic [TW-1:0] t, input logic [6:0] s);
    return {t, s, 6'h2a};
  endfunction

  task automatic put_line(input int s, w, input logic [TW-1:0] t, input logic [2:0] st);
    m_tag[s][w] = t; m_val[s][w] = 1'b1; m_st[s][w] = st;
  endtask

  // One full snoop: drive, arbitrate (grant on the gdelay-th request cycle),
  // optionally invalidate a way on the first request cycle, collect response.
  task automatic run_snoop(input string nm, input logic [6:0] s, input logic [TW-1:0] t,
                           input logic [1:0] typ, input int gdelay, input int inval_way,
                           input exp_t e);
    int reqc, wrc, lat;
    logic done, wr_now;
    logic [2:0] wst; logic wval; logic [1:0] wway; logic [6:0] wset;
    logic [LB-1:0] wlru; logic [TW-1:0] wtag;
    exp_t x;
    reqc = 0; wrc = 0; lat = -1; done = 1'b0;
    wst = '0; wval = 1'b0; wway = '0; wset = '0; wlru = '0; wtag = '0;
    sb.push_back(e);
    @(negedge clk);
    snp_req_valid = 1'b1; snp_req_addr = mk_addr(t, s); snp_req_type = typ;
    @(posedge clk); #1;
    snp_req_valid = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (snp_resp_valid) begin
        lat = k;
        x = sb.pop_front();
        check({nm, ".hit"}, snp_resp_hit, x.hit);
        check({nm, ".supply"}, snp_resp_supply, x.supply);
        check({nm, ".dirty"}, snp_resp_dirty, x.dirty);
        check({nm, ".way"}, snp_resp_way, x.way);
        check({nm, ".prev"}, snp_resp_prev_state, x.prev);
        snp_resp_ready = 1'b1;
        @(posedge clk); #1;
        snp_resp_ready = 1'b0;
        done = 1'b1;
      end else begin
        if (tag_wr_req) begin
          reqc++;
          if (reqc == 1 && inval_way >= 0) m_val[s][inval_way] = 1'b0;
          tag_wr_gnt = (reqc == gdelay);
        end else tag_wr_gnt = 1'b0;
        #1;
        wr_now = tag_wr_en;
        if (wr_now) begin
          wrc++;
          wst = tag_wr_state; wval = tag_wr_valid; wway = tag_wr_way;
          wset = tag_wr_set; wlru = tag_wr_lru; wtag = tag_wr_tag;
        end
        @(posedge clk); #1;
        tag_wr_gnt = 1'b0;
        if (wr_now) begin
          m_st[wset][wway] = wst; m_val[wset][wway] = wval;
          m_tag[wset][wway] = wtag; m_lru[wset][wway] = wlru;
        end
      end
    end
    check({nm, ".resp_seen"}, done, 1'b1);
    check({nm, ".latency"}, lat, e.lat);
    check({nm, ".req_cycles"}, reqc, e.reqc);
    check({nm, ".writes"}, wrc, e.wrc);
    if (e.wrc == 1) begin
      check({nm, ".wr_state"}, wst, e.wst);
      check({nm, ".wr_valid"}, wval, e.wval);
      check({nm, ".wr_way"}, wway, e.way);
      check({nm, ".wr_set"}, wset, s);
      check({nm, ".wr_tag"}, wtag, t);
      check({nm, ".wr_lru"}, wlru, e.way);
    end
  endtask

  initial begin
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = '0; m_val[s][w] = 1'b0; m_st[s][w] = 3'b100; m_lru[s][w] = LB'(w);
      end
    put_line(5, 2, 19'h01234, 3'b000);
    put_line(9, 0, 19'h00055, 3'b010);
    put_line(20, 1, 19'h00077, 3'b011);
    put_line(30, 3, 19'h000ab, 3'b001);
    put_line(40, 1, 19'h00040, 3'b010);
    put_line(40, 3, 19'h00040, 3'b000);
    put_line(50, 0, 19'h00010, 3'b000);

    repeat (3) @(posedge clk);
    #1;
    check("rst.req_ready", snp_req_ready, 1'b1);
    check("rst.resp_valid", snp_resp_valid, 1'b0);
    check("rst.wr_req", tag_wr_req, 1'b0);
    check("rst.rd_set", tag_rd_set, 7'd0);
    check("rst.stat_hits", snp_stat_hits, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // M hit, BusRd -> O, immediate grant
    run_snoop("t1_rd_m", 7'd5, 19'h01234, 2'b00, 1, -1,
              mk(1, 1, 1, 2'd2, 3'b000, 3, 1, 1, 3'b001, 1));
    // E hit, BusRdX, grant on third request cycle
    run_snoop("t2_rdx_e", 7'd9, 19'h00055, 2'b01, 3, -1,
              mk(1, 1, 0, 2'd0, 3'b010, 5, 3, 1, 3'b100, 0));
    // S hit, BusRd -> no write
    run_snoop("t3_rd_s", 7'd20, 19'h00077, 2'b00, 1, -1,
              mk(1, 0, 0, 2'd1, 3'b011, 2, 0, 0, 3'b000, 0));
    // tag miss across all ways
    run_snoop("t4_miss", 7'd5, 19'h00999, 2'b00, 1, -1,
              mk(0, 0, 0, 2'd0, 3'b100, 2, 0, 0, 3'b000, 0));
    // reserved type against a present line (set 5 way 2 now O)
    run_snoop("t4_rsvd", 7'd5, 19'h01234, 2'b11, 1, -1,
              mk(0, 0, 0, 2'd0, 3'b100, 2, 0, 0, 3'b000, 0));
    // O line lost to the core before grant
    run_snoop("t5_lost", 7'd30, 19'h000ab, 2'b01, 2, 3,
              mk(0, 0, 0, 2'd0, 3'b100, 4, 2, 0, 3'b000, 0));
    // two matching ways: lowest (way 1, E) wins
    run_snoop("t6_prio", 7'd40, 19'h00040, 2'b00, 1, -1,
              mk(1, 1, 0, 2'd1, 3'b010, 3, 1, 1, 3'b011, 1));
    // BusUpgr on S -> I, no supply
    run_snoop("t7_upgr", 7'd20, 19'h00077, 2'b10, 1, -1,
              mk(1, 0, 0, 2'd1, 3'b011, 3, 1, 1, 3'b100, 0));

`ifdef SNOOP_STATS_EN
    check("stat.hits", snp_stat_hits, 32'd5);
    check("stat.invals", snp_stat_invals, 32'd2);
`else
    check("stat.hits", snp_stat_hits, 32'd0);
    check("stat.invals", snp_stat_invals, 32'd0);
`endif

    // reset while waiting for the write grant
    @(negedge clk);
    snp_req_valid = 1'b1; snp_req_addr = mk_addr(19'h00010, 7'd50); snp_req_type = 2'b01;
    @(posedge clk); #1;
    snp_req_valid = 1'b0;
    for (int k = 0; k < 10 && !tag_wr_req; k++) @(negedge clk);
    @(negedge clk);
    check("rstw.in_write", tag_wr_req, 1'b1);
    tag_wr_gnt = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rstw.wr_en", tag_wr_en, 1'b0);
    check("rstw.wr_req", tag_wr_req, 1'b0);
    check("rstw.req_ready", snp_req_ready, 1'b1);
    check("rstw.rd_set", tag_rd_set, 7'd0);
    check("rstw.resp_valid", snp_resp_valid, 1'b0);
    check("rstw.stat_hits", snp_stat_hits, 32'd0);
    check("rstw.stat_invals", snp_stat_invals, 32'd0);
    @(negedge clk);
    check("rstw.wr_en_hold", tag_wr_en, 1'b0);
    tag_wr_gnt = 1'b0;
    rst_n = 1'b1;

    // line untouched by the aborted snoop: M -> O on a fresh BusRd
    run_snoop("t8_after_rst", 7'd50, 19'h00010, 2'b00, 1, -1,
              mk(1, 1, 1, 2'd0, 3'b000, 3, 1, 1, 3'b001, 1));
    @(negedge clk);
    check("idle.rd_set", tag_rd_set, 7'd0);
`ifdef SNOOP_STATS_EN
    check("stat.hits_after", snp_stat_hits, 32'd1);
`else
    check("stat.hits_after", snp_stat_hits, 32'd0);
`endif
    check("sb.empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snoop_tag_controller.md
# snoop_tag_controller

Snoop-side controller that drives the snoop read port and the single write port of the per-core MOESI tag array. It accepts one bus snoop at a time (BusRd, BusRdX, BusUpgr), looks up all ways of the addressed set, and computes the MOESI next state. It arbitrates for the shared tag write port, commits the new state, and returns a hit/supply/dirty response to the bus interconnect. It sits between the snoop bus interface and the tag array, beside the core-side cache controller that shares the write port.

## Interface
- SETS, 128, number of sets
- WAYS, 4, associativity
- ADDR_WIDTH, 32, physical address width
- TAG_WIDTH, ADDR_WIDTH-$clog2(SETS)-6, tag bits (64 B lines)
- LRU_BITS, 2, LRU field width per way (passed through, never modified)
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- snp_req_valid / snp_req_ready  in / out  1  snoop request handshake
- snp_req_addr  in  ADDR_WIDTH  snooped line address (offset = [5:0], set = next $clog2(SETS) bits, tag = rest)
- snp_req_type  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 reserved
- tag_rd_set  out  $clog2(SETS)  to tag array snoop read set
- tag_rd_tags / tag_rd_valids / tag_rd_states / tag_rd_lru  in  [WAYS][TAG_WIDTH] / [WAYS] / [WAYS][3] / [WAYS][LRU_BITS]  tag array snoop read data
- tag_wr_req  out  1  write-port request to arbiter
- tag_wr_gnt  in  1  write-port grant
- tag_wr_en, tag_wr_set, tag_wr_way, tag_wr_tag, tag_wr_valid, tag_wr_state, tag_wr_lru  out  matching tag array write port
- snp_resp_valid / snp_resp_ready  out / in  1  response handshake
- snp_resp_hit, snp_resp_supply, snp_resp_dirty  out  1 each  line present / this cache supplies data / supplied data is dirty
- snp_resp_way  out  $clog2(WAYS)  hit way
- snp_resp_prev_state  out  3  MOESI state before the snoop
- snp_stat_hits, snp_stat_invals  out  32 each  statistics counters

## Operation
- MOESI encoding: M=000, O=001, E=010, S=011, I=100.
- Hit: way with valid=1, state!=I, and tag equal. If several ways hit, the lowest index wins.
- BusRd: M→O (supply, dirty); O→O (supply, dirty); E→S (supply, clean); S→S (no supply).
- BusRdX: M/O→I (supply, dirty); E→I (supply, clean); S→I (no supply).
- BusUpgr: any hit→I, no supply.
- Reserved type and miss: no write, hit=0, supply=0, dirty=0, prev_state=I.
- Write only if the next state differs from the current state. The written tag and LRU equal the values read. tag_wr_valid = (next state != I).
- FSM:
  - IDLE (ready=1): on valid&ready, register addr and type, then go to LOOKUP.
  - LOOKUP: register the hit, way and next state. If a write is needed go to WRITE, else go to RESP.
  - WRITE: tag_wr_req=1 until grant. On the grant cycle, re-evaluate hit and next state from the current tag_rd_* values. tag_wr_en = gnt & (still needs write), valid for exactly one cycle. Then go to RESP.
  - RESP: snp_resp_valid=1 with stable fields until ready, then go to IDLE.
- The response reflects the grant-cycle evaluation when WRITE was visited. If the line was lost before grant: no write, response is a miss.

## Timing
- tag_rd_set is driven from the registered address, held from LOOKUP through WRITE. It reads 0 in IDLE.
- Minimum latency with an immediate grant (accept at cycle 0): resp_valid at cycle 3. With no write needed: cycle 2.
- One request in flight; snp_req_ready=0 outside IDLE.
- Back-to-back: the next request can be accepted the cycle after the response handshake.
- Reset values: every output is 0, except snp_req_ready=1. The FSM is in IDLE and the counters are 0.
- Reset mid-operation drops the in-flight snoop, with no partial write.
- A write-port grant while the FSM is not in WRITE is ignored.

## Configuration
- SNOOP_STATS_EN defined: snp_stat_hits increments on each response with hit=1. snp_stat_invals increments on each write with tag_wr_state=I. Both saturate at 2^32-1.
- Undefined: both counters are tied to 0 and no counter flops exist.

## Structure
- Shared package moesi_pkg:
  - MOESI state enum/localparams (M/O/E/S/I).
  - snoop type enum.
  - next-state/supply/dirty function.
- One sub-module, snoop_hit_detect: combinational tag compare plus lowest-way priority encode. It returns hit, way and state, and is used in both the LOOKUP and grant cycles.

## Test plan
- Set 5, way 2 in M; BusRd → one write with state O; response hit=1, supply=1, dirty=1, way=2, prev=000.
- Way 0 in E; BusRdX with grant delayed 3 cycles → tag_wr_req held 3 cycles; single write with valid=0, state=I; supply=1, dirty=0.
- Way 1 in S; BusRd → no tag_wr_req; resp_valid 2 cycles after accept; hit=1, supply=0.
- Tag miss across all ways and type=11 → no write; response hit=0, prev=100.
- Line in O; core invalidates it before grant → no tag_wr_en; response hit=0.
- rst_n low during WRITE → outputs reset, no write; next snoop served normally. With SNOOP_STATS_EN, counters read 0 after reset.
